// File: rtl/regfile_rd_sched.sv
// Register-file front end: clears the 32-entry RAM after reset, then serves rs1/rs2 reads over one async read port.
// Optional write-to-read forwarding is enabled by defining REGFILE_SCHED_BYPASS_EN.
module regfile_rd_sched #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(32'h0000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_rs1,
    input  logic [ADDR_WIDTH-1:0] rd_rs2,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data1,
    output logic [DATA_WIDTH-1:0] rsp_data2,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_di,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_do,
    output logic [2:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and requests/responses are held until taken.

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_RSP  = 3'd4
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   init_cnt_q;
    logic                    init_done_q;
    logic [ADDR_WIDTH-1:0]   rs1_q;
    logic [ADDR_WIDTH-1:0]   rs2_q;
    logic [DATA_WIDTH-1:0]   data1_q;
    logic [DATA_WIDTH-1:0]   data2_q;
    logic                    rsp_valid_q;

    logic                    in_init;
    logic                    wr_fire;
    logic                    wr_commit;
    logic                    rd_fire;
    logic [DATA_WIDTH-1:0]   rd_word_d;
    logic [DATA_WIDTH-1:0]   cap_data_d;

    assign in_init = (state_q == S_INIT);

`ifdef REGFILE_SCHED_BYPASS_EN
    assign wr_ready = !in_init;
`else
    // Writes stall while the read port is busy so a read never races a write.
    assign wr_ready = !in_init && (state_q != S_RD1) && (state_q != S_RD2);
`endif

    assign wr_fire   = wr_valid && wr_ready;
    assign wr_commit = wr_fire && (wr_addr != '0);

    assign rd_ready = (state_q == S_IDLE) || ((state_q == S_RSP) && rsp_ready);
    assign rd_fire  = rd_valid && rd_ready;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_di    = '0;
        if (in_init) begin
            ram_we    = 1'b1;
            ram_waddr = init_cnt_q;
            ram_di    = INIT_VALUE;
        end else if (wr_commit) begin
            ram_we    = 1'b1;
            ram_waddr = wr_addr;
            ram_di    = wr_data;
        end
    end

    always_comb begin
        ram_raddr = '0;
        case (state_q)
            S_RD1:   ram_raddr = rs1_q;
            S_RD2:   ram_raddr = rs2_q;
            default: ram_raddr = '0;
        endcase
    end

`ifdef REGFILE_SCHED_BYPASS_EN
    assign rd_word_d = (wr_commit && (wr_addr == ram_raddr)) ? wr_data : ram_do;
`else
    assign rd_word_d = ram_do;
`endif

    // x0 reads as zero no matter what the RAM holds at index 0.
    assign cap_data_d = (ram_raddr == '0) ? '0 : rd_word_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (&init_cnt_q) begin
                        state_q     <= S_IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (rd_fire) begin
                        rs1_q   <= rd_rs1;
                        rs2_q   <= rd_rs2;
                        state_q <= S_RD1;
                    end
                end
                S_RD1: begin
                    data1_q <= cap_data_d;
                    state_q <= S_RD2;
                end
                S_RD2: begin
                    data2_q     <= cap_data_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (rd_valid) begin
                            rs1_q   <= rd_rs1;
                            rs2_q   <= rd_rs2;
                            state_q <= S_RD1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign init_done = init_done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data1 = data1_q;
    assign rsp_data2 = data2_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_rd_sched.sv
// Directed bench for regfile_rd_sched with a behavioural 32x32 async-read RAM attached.
module tb_regfile_rd_sched;

    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_RD1  = 3'd2;
    localparam logic [2:0] ST_RD2  = 3'd3;
    localparam logic [2:0] ST_RSP  = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  rd_rs1;
    logic [4:0]  rd_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data1;
    logic [31:0] rsp_data2;
    logic        ram_we;
    logic [4:0]  ram_waddr;
    logic [31:0] ram_di;
    logic [4:0]  ram_raddr;
    logic [31:0] ram_do;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // clock / reset
    always #5 clk = ~clk;

    regfile_rd_sched dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_rs1    (rd_rs1),
        .rd_rs2    (rd_rs2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data1 (rsp_data1),
        .rsp_data2 (rsp_data2),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_di    (ram_di),
        .ram_raddr (ram_raddr),
        .ram_do    (ram_do),
        .dbg_state (dbg_state)
    );

    // RAM model: garbage while in reset so the clear sequence is observable,
    // plus a backdoor poke used to plant a nonzero value at index 0.
    logic [31:0] mem [32];
    logic        poke_en = 1'b0;
    logic [4:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hBAD0_0000 | 32'(i);
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (ram_we) begin
            mem[ram_waddr] <= ram_di;
        end
    end

    assign ram_do = mem[ram_raddr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first cycle after reset is released; a write is held
    // pending the whole time and must not be accepted.
    task automatic check_init_seq();
        wr_valid = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 32'h5555_5555;
        for (int i = 0; i < 32; i++) begin
            #1;
            check_eq("init_we", ram_we, 1);
            check_eq("init_waddr", ram_waddr, i);
            check_eq("init_di", ram_di, 0);
            check_eq("init_wr_ready", wr_ready, 0);
            check_eq("init_done_low", init_done, 0);
            tick();
        end
        wr_valid = 1'b0;
        #1;
        check_eq("post_init_done", init_done, 1);
        check_eq("post_init_wr_ready", wr_ready, 1);
        check_eq("post_init_rd_ready", rd_ready, 1);
        check_eq("post_init_state", dbg_state, ST_IDLE);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        #1;
        check_eq("wr_ready", wr_ready, 1);
        check_eq("wr_ram_we", ram_we, (a != 0) ? 1 : 0);
        if (a != 0) begin
            check_eq("wr_ram_waddr", ram_waddr, a);
            check_eq("wr_ram_di", ram_di, d);
        end
        tick();
        wr_valid = 1'b0;
    endtask

    // Full read from IDLE with the response taken immediately.
    task automatic do_read(input logic [4:0] a, input logic [4:0] b,
                           input logic [31:0] e1, input logic [31:0] e2);
        rd_valid = 1'b1;
        rd_rs1   = a;
        rd_rs2   = b;
        #1;
        check_eq("rd_ready_idle", rd_ready, 1);
        tick();
        rd_valid = 1'b0;
        #1;
        check_eq("rd1_state", dbg_state, ST_RD1);
        check_eq("rd1_raddr", ram_raddr, a);
        check_eq("rd1_rsp_valid", rsp_valid, 0);
        tick();
        check_eq("rd2_raddr", ram_raddr, b);
        tick();
        check_eq("rsp_valid", rsp_valid, 1);
        check_eq("rsp_data1", rsp_data1, e1);
        check_eq("rsp_data2", rsp_data2, e2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check_eq("rsp_done_valid", rsp_valid, 0);
        check_eq("rsp_done_state", dbg_state, ST_IDLE);
    endtask

    logic [4:0]  req_a [3];
    logic [4:0]  req_b [3];
    logic [31:0] exp_a [3];
    logic [31:0] exp_b [3];

    initial begin
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_valid  = 1'b0;
        rd_rs1    = '0;
        rd_rs2    = '0;
        rsp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_state", dbg_state, ST_INIT);
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data1", rsp_data1, 0);
        check_eq("rst_rsp_data2", rsp_data2, 0);
        check_eq("rst_rd_ready", rd_ready, 0);
        rst = 1'b0;
        check_init_seq();

        // Basic read with response held under back-pressure
        write_reg(5'd5, 32'hDEAD_BEEF);
        write_reg(5'd7, 32'h1234_5678);
        rd_valid = 1'b1;
        rd_rs1   = 5'd5;
        rd_rs2   = 5'd7;
        #1;
        check_eq("basic_rd_ready", rd_ready, 1);
        tick();
        rd_valid = 1'b0;
        check_eq("basic_t1_valid", rsp_valid, 0);
        tick();
        check_eq("basic_t2_valid", rsp_valid, 0);
        tick();
        check_eq("basic_t3_valid", rsp_valid, 1);
        check_eq("basic_data1", rsp_data1, 32'hDEAD_BEEF);
        check_eq("basic_data2", rsp_data2, 32'h1234_5678);
        check_eq("basic_hold_rd_ready", rd_ready, 0);
        // Overwrite x5 while the response waits: held data must not change
        write_reg(5'd5, 32'h1111_1111);
        tick();
        check_eq("hold_valid", rsp_valid, 1);
        check_eq("hold_data1", rsp_data1, 32'hDEAD_BEEF);
        check_eq("hold_data2", rsp_data2, 32'h1234_5678);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check_eq("basic_drain_valid", rsp_valid, 0);
        check_eq("basic_drain_state", dbg_state, ST_IDLE);

        // x0: write ignored, reads return 0 even if the RAM holds junk at 0
        write_reg(5'd0, 32'hFFFF_FFFF);
        poke_en   = 1'b1;
        poke_addr = 5'd0;
        poke_data = 32'hFFFF_FFFF;
        tick();
        poke_en = 1'b0;
        do_read(5'd0, 5'd0, 32'h0, 32'h0);

        // Write colliding with the RD1 read of x3 (x3 currently 0)
        rd_valid = 1'b1;
        rd_rs1   = 5'd3;
        rd_rs2   = 5'd7;
        tick();
        rd_valid = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 5'd3;
        wr_data  = 32'hA5A5_A5A5;
        #1;
        check_eq("coll_rd1_raddr", ram_raddr, 3);
`ifdef REGFILE_SCHED_BYPASS_EN
        check_eq("coll_rd1_wr_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        tick();
        check_eq("coll_rsp_valid", rsp_valid, 1);
        check_eq("coll_data1", rsp_data1, 32'hA5A5_A5A5);
`else
        check_eq("coll_rd1_wr_ready", wr_ready, 0);
        check_eq("coll_rd1_ram_we", ram_we, 0);
        tick();
        check_eq("coll_rd2_wr_ready", wr_ready, 0);
        tick();
        check_eq("coll_rsp_valid", rsp_valid, 1);
        check_eq("coll_rsp_wr_ready", wr_ready, 1);
        check_eq("coll_rsp_ram_we", ram_we, 1);
        check_eq("coll_rsp_waddr", ram_waddr, 3);
        check_eq("coll_data1", rsp_data1, 32'h0);
        tick();
        wr_valid = 1'b0;
`endif
        check_eq("coll_data2", rsp_data2, 32'h1234_5678);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        do_read(5'd3, 5'd5, 32'hA5A5_A5A5, 32'h1111_1111);

        // Back-to-back: three requests, one response every 3 cycles
        write_reg(5'd1, 32'h0000_0011);
        write_reg(5'd2, 32'h0000_0022);
        write_reg(5'd4, 32'h0000_0044);
        write_reg(5'd6, 32'h0000_0066);
        req_a[0] = 5'd1; req_b[0] = 5'd2; exp_a[0] = 32'h0000_0011; exp_b[0] = 32'h0000_0022;
        req_a[1] = 5'd4; req_b[1] = 5'd6; exp_a[1] = 32'h0000_0044; exp_b[1] = 32'h0000_0066;
        req_a[2] = 5'd5; req_b[2] = 5'd3; exp_a[2] = 32'h1111_1111; exp_b[2] = 32'hA5A5_A5A5;
        rd_valid  = 1'b1;
        rsp_ready = 1'b1;
        rd_rs1    = req_a[0];
        rd_rs2    = req_b[0];
        tick();
        for (int k = 0; k < 3; k++) begin
            if (k < 2) begin
                rd_rs1 = req_a[k+1];
                rd_rs2 = req_b[k+1];
            end else begin
                rd_valid = 1'b0;
            end
            #1;
            check_eq("b2b_rd1_state", dbg_state, ST_RD1);
            check_eq("b2b_rd1_valid", rsp_valid, 0);
            tick();
            tick();
            check_eq("b2b_rsp_valid", rsp_valid, 1);
            check_eq("b2b_data1", rsp_data1, exp_a[k]);
            check_eq("b2b_data2", rsp_data2, exp_b[k]);
            check_eq("b2b_rd_ready", rd_ready, 1);
            tick();
        end
        rsp_ready = 1'b0;
        check_eq("b2b_end_state", dbg_state, ST_IDLE);
        check_eq("b2b_end_valid", rsp_valid, 0);

        // Reset asserted in RD2 aborts the request and reruns the clear
        rd_valid = 1'b1;
        rd_rs1   = 5'd1;
        rd_rs2   = 5'd2;
        tick();
        rd_valid = 1'b0;
        tick();
        check_eq("abort_pre_state", dbg_state, ST_RD2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_rsp_valid", rsp_valid, 0);
        check_eq("abort_state", dbg_state, ST_INIT);
        check_eq("abort_init_done", init_done, 0);
        check_init_seq();
        do_read(5'd5, 5'd3, 32'h0, 32'h0);
        do_read(5'd1, 5'd7, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
